// File: rtl/qspi_target_pkg.sv
// QSPI responder shared types and constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package qspi_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_e;

    localparam logic [7:0] CMD_READ_DEF  = 8'hEB;
    localparam logic [7:0] CMD_WRITE_DEF = 8'h38;

    // Shared bit/nibble/dummy counter width; wide enough for any sane dummy count.
    localparam int CNT_W        = 8;
    localparam int CMD_BITS     = 8;
    localparam int ADDR_NIBBLES = 6;

endpackage

// File: rtl/qspi_target_if.sv
// Pad-side QSPI lines plus the local memory port and status of the QSPI responder.
// Latency: n/a (wiring only).
// Backpressure: none; the memory must return read data the clk after mem_re.
// master: QSPI host + memory model side; slave: the responder (qspi_target).
interface qspi_target_if #(
    parameter int ADDR_W = 16
);
    logic              sclk_in;
    logic              cs_n_in;
    logic [3:0]        io_in;
    logic [3:0]        io_out;
    logic [3:0]        io_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [7:0]        mem_rdata;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              cmd_err;

    modport master (
        output sclk_in, cs_n_in, io_in, mem_rdata,
        input  io_out, io_oe, mem_addr, mem_re, mem_we, mem_wdata, busy, cmd_err
    );

    modport slave (
        input  sclk_in, cs_n_in, io_in, mem_rdata,
        output io_out, io_oe, mem_addr, mem_re, mem_we, mem_wdata, busy, cmd_err
    );
endinterface

// File: rtl/qspi_sync_edge.sv
// 2-flop synchronizer with rise/fall detection on the synchronized level.
// Latency: edges reported 2-3 clk after the pad transition, as 1-clk pulses.
// Backpressure: none.
// Ports: clk/rst, d_i async input, rise_o/fall_o single-cycle edge pulses.
module qspi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic s1_q, s2_q, s3_q;

    // All flops reset low: a cs_n already low when reset releases then never
    // looks like a fall, so a new transaction needs a real high-then-low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;
    assign fall_o = ~s2_q & s3_q;
endmodule

// File: rtl/qspi_target.sv
// QSPI target: decodes cmd + 24-bit address, streams bytes from/to a local sync memory.
// Latency: pad edges seen 3 clk late; io/mem outputs registered 1 clk after a detected edge.
// Backpressure: none; memory must return mem_rdata the clk after mem_re, writes always accepted.
// Ports: clk, rst (async, active high); bus = qspi_target_if.slave carrying sclk/cs_n/io
// pads, the memory port (mem_addr/re/rdata/we/wdata) and busy/cmd_err status.
// ADDR_W must lie in 11..24 (address shifter holds only the retained bits).
module qspi_target
    import qspi_target_pkg::*;
#(
    parameter int         ADDR_W       = 16,
    parameter int         DUMMY_CYCLES = 4,
    parameter logic [7:0] CMD_READ     = CMD_READ_DEF,
    parameter logic [7:0] CMD_WRITE    = CMD_WRITE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    qspi_target_if.slave bus
);
    localparam int SH_W = ADDR_W - 4;
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_NIBBLES - 1);
    localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [3:0] io_s1_q, io_s2_q;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SH_W-1:0]    shift_q, shift_d;
    logic               nib_q, nib_d;          // 0: high nibble next, 1: low nibble next
    logic               is_wr_q, is_wr_d;
    logic [7:0]         byte_q, byte_d;        // byte currently being shifted out
    logic [7:0]         pf_q, pf_d;            // prefetched next byte
    logic               rd_to_pf_q, rd_to_pf_d;
    logic               re_d1_q, re_d1_d;      // mem_rdata valid this clk
    logic [3:0]         io_out_q, io_out_d;
    logic [3:0]         io_oe_q, io_oe_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               mem_re_q, mem_re_d;
    logic               mem_we_q, mem_we_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;
    logic               busy_q, busy_d;
    logic               cmd_err_q, cmd_err_d;

    qspi_sync_edge u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (bus.sclk_in),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    qspi_sync_edge u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (bus.cs_n_in),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // Same depth as the sclk path so data is aligned with the detected rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_s1_q <= 4'h0;
            io_s2_q <= 4'h0;
        end else begin
            io_s1_q <= bus.io_in;
            io_s2_q <= io_s1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            nib_q       <= 1'b0;
            is_wr_q     <= 1'b0;
            byte_q      <= 8'h00;
            pf_q        <= 8'h00;
            rd_to_pf_q  <= 1'b0;
            re_d1_q     <= 1'b0;
            io_out_q    <= 4'h0;
            io_oe_q     <= 4'h0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            busy_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            nib_q       <= nib_d;
            is_wr_q     <= is_wr_d;
            byte_q      <= byte_d;
            pf_q        <= pf_d;
            rd_to_pf_q  <= rd_to_pf_d;
            re_d1_q     <= re_d1_d;
            io_out_q    <= io_out_d;
            io_oe_q     <= io_oe_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        nib_d       = nib_q;
        is_wr_d     = is_wr_q;
        byte_d      = byte_q;
        pf_d        = pf_q;
        rd_to_pf_d  = rd_to_pf_q;
        re_d1_d     = mem_re_q;
        io_out_d    = io_out_q;
        io_oe_d     = io_oe_q;
        mem_addr_d  = mem_addr_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        cmd_err_d   = cmd_err_q;

        // The write strobe used the current address; step past it afterwards.
        if (mem_we_q) begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
        end

        if (cs_rise) begin
            // Deselect wins over everything, including a coincident sclk edge
            // and any read still in flight.
            state_d  = ST_IDLE;
            cnt_d    = '0;
            nib_d    = 1'b0;
            re_d1_d  = 1'b0;
            io_out_d = 4'h0;
            io_oe_d  = 4'h0;
            busy_d   = 1'b0;
        end else begin
            if (re_d1_q) begin
                if (rd_to_pf_q) begin
                    pf_d = bus.mem_rdata;
                end else begin
                    byte_d = bus.mem_rdata;
                end
            end

            // Outside IDLE, cs_n is low (its rise is handled above), so sclk
            // edges seen here always belong to the current transaction.
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d = ST_CMD;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        nib_d   = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shift_d = {shift_q[SH_W-2:0], io_s2_q[0]};
                        if (cnt_q == CMD_LAST) begin
                            cnt_d = '0;
                            if ({shift_q[6:0], io_s2_q[0]} == CMD_READ) begin
                                state_d = ST_ADDR;
                                is_wr_d = 1'b0;
                            end else if ({shift_q[6:0], io_s2_q[0]} == CMD_WRITE) begin
                                state_d = ST_ADDR;
                                is_wr_d = 1'b1;
                            end else begin
                                state_d   = ST_IGNORE;
                                cmd_err_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        // Only the low ADDR_W address bits are ever kept.
                        shift_d = {shift_q[SH_W-5:0], io_s2_q};
                        if (cnt_q == ADDR_LAST) begin
                            cnt_d      = '0;
                            nib_d      = 1'b0;
                            mem_addr_d = {shift_q, io_s2_q};
                            if (is_wr_q) begin
                                state_d = ST_WDATA;
                            end else begin
                                mem_re_d   = 1'b1;
                                rd_to_pf_d = 1'b0;
                                state_d    = (DUMMY_CYCLES == 0) ? ST_RDATA : ST_DUMMY;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sclk_rise) begin
                        if (cnt_q == DUMMY_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_RDATA;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_RDATA: begin
                    if (sclk_fall) begin
                        io_oe_d = 4'hF;
                        if (!nib_q) begin
                            // High nibble out; fetch the following byte meanwhile.
                            io_out_d   = byte_q[7:4];
                            mem_addr_d = mem_addr_q + ADDR_W'(1);
                            mem_re_d   = 1'b1;
                            rd_to_pf_d = 1'b1;
                            nib_d      = 1'b1;
                        end else begin
                            io_out_d = byte_q[3:0];
                            byte_d   = pf_q;
                            nib_d    = 1'b0;
                        end
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise) begin
                        if (!nib_q) begin
                            shift_d = {shift_q[SH_W-5:0], io_s2_q};
                            nib_d   = 1'b1;
                        end else begin
                            mem_wdata_d = {shift_q[3:0], io_s2_q};
                            mem_we_d    = 1'b1;
                            nib_d       = 1'b0;
                        end
                    end
                end
                ST_IGNORE: begin
                    io_oe_d = 4'h0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.io_out    = io_out_q;
    assign bus.io_oe     = io_oe_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.cmd_err   = cmd_err_q;
endmodule

// File: tb/tb_qspi_target.sv
module tb_qspi_target;
    localparam int ADDR_W = 16;
    localparam int DUMMY  = 4;
    localparam int HALF   = 80;          // half sclk period = 8 clk periods
    localparam int MEM_SZ = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0]        mem [0:MEM_SZ-1];
    logic [ADDR_W-1:0] re_log [$];
    logic [ADDR_W+7:0] we_log [$];

    qspi_target_if #(.ADDR_W(ADDR_W)) bus ();

    qspi_target #(
        .ADDR_W       (ADDR_W),
        .DUMMY_CYCLES (DUMMY),
        .CMD_READ     (8'hEB),
        .CMD_WRITE    (8'h38)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous memory with access logging.
    always @(posedge clk) begin
        if (bus.mem_re) begin
            bus.mem_rdata <= mem[bus.mem_addr];
            re_log.push_back(bus.mem_addr);
        end
        if (bus.mem_we) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            we_log.push_back({bus.mem_addr, bus.mem_wdata});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nib_out(input logic [3:0] v);
        bus.io_in = v;
        #(HALF);
        bus.sclk_in = 1'b1;
        #(HALF);
        bus.sclk_in = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) nib_out({3'($urandom), c[i]});
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) nib_out(a[i*4 +: 4]);
    endtask

    task automatic dummy_phase(input string tag);
        for (int i = 0; i < DUMMY; i++) begin
            bus.io_in = 4'($urandom);
            #(HALF);
            bus.sclk_in = 1'b1;
            chk(tag, 32'(bus.io_oe), 32'h0);
            #(HALF);
            bus.sclk_in = 1'b0;
        end
    endtask

    // One master sample on a rising edge; when last, cs_n rises together with the closing fall.
    task automatic nib_in(input logic last, output logic [3:0] v, output logic [3:0] oe);
        #(HALF);
        bus.sclk_in = 1'b1;
        v  = bus.io_out;
        oe = bus.io_oe;
        #(HALF);
        bus.sclk_in = 1'b0;
        if (last) bus.cs_n_in = 1'b1;
    endtask

    task automatic cs_start();
        bus.cs_n_in = 1'b0;
        #(HALF);
    endtask

    task automatic cs_idle();
        bus.cs_n_in = 1'b1;
        #(2*HALF);
    endtask

    // Reference: n bytes from (a mod 2^ADDR_W) upward with wrap; reads touch a..a+n.
    task automatic do_read(input string tag, input logic [23:0] a, input int n);
        logic [3:0] v, oe;
        logic [7:0] exp_b;
        int base;
        base = int'(a) % MEM_SZ;
        re_log.delete();
        we_log.delete();
        cs_start();
        chk({tag, "_busy_on"}, 32'(bus.busy), 32'h1);
        send_cmd(8'hEB);
        send_addr(a);
        dummy_phase({tag, "_dummy_oe"});
        for (int b = 0; b < n; b++) begin
            exp_b = mem[(base + b) % MEM_SZ];
            nib_in(1'b0, v, oe);
            chk({tag, "_hi"}, 32'(v), 32'(exp_b[7:4]));
            chk({tag, "_oe"}, 32'(oe), 32'hF);
            nib_in(b == n - 1, v, oe);
            chk({tag, "_lo"}, 32'(v), 32'(exp_b[3:0]));
        end
        #(2*HALF);
        chk({tag, "_busy_off"}, 32'(bus.busy), 32'h0);
        chk({tag, "_oe_off"}, 32'(bus.io_oe), 32'h0);
        chk({tag, "_re_cnt"}, 32'(re_log.size()), 32'(n + 1));
        for (int k = 0; k <= n; k++)
            if (k < re_log.size()) chk({tag, "_re_addr"}, 32'(re_log[k]), 32'((base + k) % MEM_SZ));
        chk({tag, "_we_cnt"}, 32'(we_log.size()), 32'h0);
    endtask

    task automatic do_write(input string tag, input logic [23:0] a, input logic [7:0] data [4],
                            input int n, input logic tail, input logic [3:0] tail_nib);
        int base;
        base = int'(a) % MEM_SZ;
        re_log.delete();
        we_log.delete();
        cs_start();
        send_cmd(8'h38);
        send_addr(a);
        for (int b = 0; b < n; b++) begin
            nib_out(data[b][7:4]);
            nib_out(data[b][3:0]);
        end
        if (tail) nib_out(tail_nib);
        cs_idle();
        chk({tag, "_we_cnt"}, 32'(we_log.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (k < we_log.size())
                chk({tag, "_we"}, 32'(we_log[k]), 32'({16'((base + k) % MEM_SZ), data[k]}));
            chk({tag, "_mem"}, 32'(mem[(base + k) % MEM_SZ]), 32'(data[k]));
        end
        chk({tag, "_re_cnt"}, 32'(re_log.size()), 32'h0);
        chk({tag, "_busy_off"}, 32'(bus.busy), 32'h0);
    endtask

    initial begin
        logic [7:0]  wd [4];
        logic [7:0]  keep_b;
        logic [23:0] a;
        logic [3:0]  v, oe;
        int          n;

        bus.sclk_in = 1'b0;
        bus.cs_n_in = 1'b1;
        bus.io_in   = 4'h0;
        rst         = 1'b1;
        for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'($urandom);

        #1;
        chk("rst_io", 32'({bus.io_out, bus.io_oe}), 32'h0);
        chk("rst_mem", 32'({bus.mem_addr, bus.mem_re, bus.mem_we, bus.mem_wdata}), 32'h0);
        chk("rst_status", 32'({bus.busy, bus.cmd_err}), 32'h0);
        #99;
        rst = 1'b0;
        #(2*HALF);

        // Directed burst and address wrap.
        mem[16'h0010] = 8'h11;
        mem[16'h0011] = 8'h22;
        mem[16'h0012] = 8'h33;
        mem[16'h0013] = 8'h44;
        do_read("burst", 24'h000010, 4);
        mem[16'hFFFF] = 8'hA5;
        mem[16'h0000] = 8'h5A;
        do_read("wrap", 24'h00FFFF, 2);

        // Random reads; upper address bits are random garbage to be discarded.
        for (int r = 0; r < 3; r++) do_read("rnd_read", 24'($urandom), int'($urandom_range(1, 5)));

        // Directed write with a trailing half byte.
        wd[0] = 8'hDE; wd[1] = 8'hAD; wd[2] = 8'h00; wd[3] = 8'h00;
        keep_b = mem[16'h0022];
        do_write("write", 24'h000020, wd, 2, 1'b1, 4'hB);
        chk("write_tail", 32'(mem[16'h0022]), 32'(keep_b));

        // Random write then read back.
        for (int i = 0; i < 4; i++) wd[i] = 8'($urandom);
        n = int'($urandom_range(1, 4));
        a = 24'($urandom);
        do_write("rnd_write", a, wd, n, 1'($urandom), 4'($urandom));
        do_read("readback", a, n);

        // Abort after three address nibbles.
        re_log.delete();
        we_log.delete();
        cs_start();
        send_cmd(8'hEB);
        for (int i = 0; i < 3; i++) nib_out(4'($urandom));
        #(HALF);
        chk("abort_busy_mid", 32'(bus.busy), 32'h1);
        bus.cs_n_in = 1'b1;
        #30;
        chk("abort_busy_3clk", 32'(bus.busy), 32'h0);
        #130;
        chk("abort_no_access", 32'(re_log.size() + we_log.size()), 32'h0);
        do_read("after_abort", 24'($urandom), 3);

        // Unknown opcode.
        re_log.delete();
        we_log.delete();
        cs_start();
        send_cmd(8'h9F);
        chk("badop_err", 32'(bus.cmd_err), 32'h1);
        for (int i = 0; i < 8; i++) begin
            bus.io_in = 4'($urandom);
            nib_in(1'b0, v, oe);
            chk("badop_oe", 32'(oe), 32'h0);
        end
        cs_idle();
        chk("badop_no_access", 32'(re_log.size() + we_log.size()), 32'h0);
        do_read("after_badop", 24'($urandom), 2);
        chk("badop_sticky", 32'(bus.cmd_err), 32'h1);

        // Reset in the middle of read data.
        a = 24'($urandom);
        cs_start();
        send_cmd(8'hEB);
        send_addr(a);
        dummy_phase("rstmid_dummy_oe");
        nib_in(1'b0, v, oe);
        chk("rstmid_hi", 32'(v), 32'(mem[int'(a) % MEM_SZ][7:4]));
        nib_in(1'b0, v, oe);
        chk("rstmid_lo", 32'(v), 32'(mem[int'(a) % MEM_SZ][3:0]));
        #30;
        rst = 1'b1;
        #1;
        chk("rstmid_io", 32'({bus.io_out, bus.io_oe}), 32'h0);
        chk("rstmid_mem", 32'({bus.mem_addr, bus.mem_re, bus.mem_we, bus.mem_wdata}), 32'h0);
        chk("rstmid_status", 32'({bus.busy, bus.cmd_err}), 32'h0);
        #49;
        rst = 1'b0;
        re_log.delete();
        we_log.delete();
        // cs_n stayed low across reset: a whole read sequence must be ignored.
        send_cmd(8'hEB);
        send_addr(a);
        for (int i = 0; i < DUMMY + 4; i++) begin
            nib_in(1'b0, v, oe);
            chk("rstmid_no_drive", 32'(oe), 32'h0);
        end
        chk("rstmid_busy", 32'(bus.busy), 32'h0);
        chk("rstmid_no_access", 32'(re_log.size() + we_log.size()), 32'h0);
        cs_idle();
        do_read("after_rst", a, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
